// File: rtl/axi_chan_demux_1xn_if.sv
// Valid/ready channel bundle for the 1-to-N demux.
// One source lane plus NUM_OUT sink lanes.
interface axi_chan_demux_1xn_if #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 32
);
  localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_W-1:0]         s_data;
  logic                      s_last;
  logic [SEL_W-1:0]          s_sel;
  logic [NUM_OUT-1:0]        m_valid;
  logic [NUM_OUT-1:0]        m_ready;
  logic [NUM_OUT*DATA_W-1:0] m_data;
  logic [NUM_OUT-1:0]        m_last;

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/axi_chan_demux_1xn.sv
// 1-to-N burst demux for a valid/ready channel.
// Target locks on the first beat until the last beat is accepted.
module axi_chan_demux_1xn #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 32,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  axi_chan_demux_1xn_if.slave ch,
  output logic                busy,
  output logic                sel_err
);
  localparam int SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] eff_sel;
  logic             sel_ok;
  logic             acc;

  assign eff_sel = (state == LOCKED) ? lock_sel : ch.s_sel;
  assign sel_ok  = {1'b0, eff_sel} < (SEL_W+1)'(NUM_OUT);
  assign acc     = ch.s_valid && ch.s_ready;
  assign busy    = (state == LOCKED);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= IDLE;
      lock_sel <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= acc && (state == IDLE) && !sel_ok;
      if (acc) begin
        case (state)
          IDLE: begin
            lock_sel <= ch.s_sel;
            if (!ch.s_last) state <= LOCKED;
          end
          LOCKED: if (ch.s_last) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  if (REG_OUT) begin : g_reg
    logic              ov;
    logic              olast;
    logic [SEL_W-1:0]  osel;
    logic [DATA_W-1:0] odata;
    logic              drain;
    logic              load;

    assign drain = |(ch.m_valid & ch.m_ready);
    // Beats to an invalid target bypass the register entirely.
    assign load  = acc && sel_ok;
    assign ch.s_ready = ARESETN && (!ov || drain || !sel_ok);

    always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
        ov    <= 1'b0;
        olast <= 1'b0;
        osel  <= '0;
        odata <= '0;
      end else if (load) begin
        ov    <= 1'b1;
        olast <= ch.s_last;
        osel  <= eff_sel;
        odata <= ch.s_data;
      end else if (drain) begin
        ov <= 1'b0;
      end
    end

    always_comb begin
      ch.m_valid = '0;
      ch.m_data  = '0;
      ch.m_last  = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (ov && osel == SEL_W'(i)) begin
          ch.m_valid[i]                 = 1'b1;
          ch.m_data[i*DATA_W +: DATA_W] = odata;
          ch.m_last[i]                  = olast;
        end
      end
    end
  end else begin : g_comb
    logic [NUM_OUT-1:0] hot;

    always_comb begin
      hot = '0;
      for (int i = 0; i < NUM_OUT; i++)
        hot[i] = (eff_sel == SEL_W'(i));
    end

    assign ch.s_ready = ARESETN && (!sel_ok || |(ch.m_ready & hot));

    always_comb begin
      ch.m_valid = '0;
      ch.m_data  = '0;
      ch.m_last  = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (ARESETN && ch.s_valid && hot[i]) begin
          ch.m_valid[i]                 = 1'b1;
          ch.m_data[i*DATA_W +: DATA_W] = ch.s_data;
          ch.m_last[i]                  = ch.s_last;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_chan_demux_1xn.sv
// Scoreboard bench for axi_chan_demux_1xn.
// DUT0: N=4 registered, DUT1: N=4 combinational, DUT2: N=3 registered.
module tb_axi_chan_demux_1xn;
  logic clk;
  logic rst_n;

  logic [2:0]        sv;
  logic [2:0]        sl;
  logic [2:0][1:0]   ss;
  logic [2:0][31:0]  sd;
  logic [2:0][3:0]   mr;
  wire  [2:0]        sr;
  wire  [2:0]        bz;
  wire  [2:0]        se;
  wire  [2:0][3:0]   mv;
  wire  [2:0][3:0]   ml;
  wire  [2:0][127:0] md;

  typedef struct packed {
    logic [1:0]  sink;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total;
  int passed;
  int cyc;
  int errcnt;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int N = (k == 2) ? 3 : 4;
    localparam bit R = (k == 1) ? 1'b0 : 1'b1;

    axi_chan_demux_1xn_if #(.NUM_OUT(N), .DATA_W(32)) bus ();

    assign bus.s_valid = sv[k];
    assign bus.s_data  = sd[k];
    assign bus.s_last  = sl[k];
    assign bus.s_sel   = ss[k];
    assign bus.m_ready = mr[k][N-1:0];
    assign sr[k]       = bus.s_ready;
    assign mv[k]       = 4'(bus.m_valid);
    assign ml[k]       = 4'(bus.m_last);
    assign md[k]       = 128'(bus.m_data);

    axi_chan_demux_1xn #(
      .NUM_OUT(N),
      .DATA_W (32),
      .REG_OUT(R)
    ) dut (
      .ACLK   (clk),
      .ARESETN(rst_n),
      .ch     (bus.slave),
      .busy   (bz[k]),
      .sel_err(se[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (se[2]) errcnt = errcnt + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic void push(input int k, input int s,
                               input logic [31:0] d, input logic l);
    exp_t e;
    e.sink = 2'(s);
    e.data = d;
    e.last = l;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Monitor: every sink handshake pops the next expected beat.
  always @(negedge clk) begin
    exp_t        e;
    bit          have;
    logic [3:0]  oh;
    logic [127:0] dm;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (mv[k][i]) begin
            oh = 4'b0001 << i;
            dm = md[k];
            dm[i*32 +: 32] = '0;
            chk($sformatf("onehot_d%0d", k), mv[k], oh);
            chk($sformatf("others_zero_d%0d", k),
                (dm == '0) && ((ml[k] & ~oh) == '0), 1);
            if (mr[k][i]) begin
              have = 0;
              case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                default:
                   if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
              endcase
              if (!have) begin
                total++;
                $display("FAIL spurious_beat d%0d: got sink %0d data %0h want none",
                         k, i, md[k][i*32 +: 32]);
              end else begin
                chk($sformatf("sink_d%0d", k), i, e.sink);
                chk($sformatf("data_d%0d", k), md[k][i*32 +: 32], e.data);
                chk($sformatf("last_d%0d", k), ml[k][i], e.last);
              end
            end
          end
        end
      end
    end
  end

  // Drive one beat; xs<0 means the beat is expected to be dropped.
  task automatic beat(input int k, input logic [1:0] sel, input int xs,
                      input logic [31:0] d, input logic l);
    int n;
    sv[k] = 1'b1;
    ss[k] = sel;
    sd[k] = d;
    sl[k] = l;
    if (xs >= 0) push(k, xs, d, l);
    n = 0;
    @(negedge clk);
    while (!sr[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sr[k]) begin
      total++;
      $display("FAIL accept_timeout d%0d: got no s_ready want s_ready", k);
    end
    @(posedge clk);
    #1;
    sv[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    total  = 0;
    passed = 0;
    cyc    = 0;
    errcnt = 0;
    rst_n  = 1'b0;
    sv     = '0;
    sl     = '0;
    ss     = '0;
    sd     = '0;
    mr     = {4'hF, 4'hF, 4'hF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_sready_d%0d", k), sr[k], 0);
      chk($sformatf("rst_mvalid_d%0d", k), mv[k], 0);
      chk($sformatf("rst_mdata_d%0d", k), md[k], 0);
      chk($sformatf("rst_busy_d%0d", k), bz[k], 0);
      chk($sformatf("rst_selerr_d%0d", k), se[k], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // T1: 3-beat burst to sink 2
    beat(0, 2'd2, 2, 32'hA0, 1'b0);
    chk("t1_lat_valid", mv[0], 4'b0100);
    chk("t1_lat_data", md[0][64 +: 32], 32'hA0);
    chk("t1_busy_a0", bz[0], 1);
    beat(0, 2'd2, 2, 32'hA1, 1'b0);
    chk("t1_busy_a1", bz[0], 1);
    beat(0, 2'd2, 2, 32'hA2, 1'b1);
    chk("t1_busy_a2", bz[0], 0);
    chk("t1_last", ml[0], 4'b0100);
    idle(3);

    // T2: mid-burst sel change ignored, both modes
    for (int k = 0; k < 2; k++) begin
      beat(k, 2'd1, 1, 32'hB0, 1'b0);
      beat(k, 2'd3, 1, 32'hB1, 1'b0);
      beat(k, 2'd3, 1, 32'hB2, 1'b1);
      beat(k, 2'd3, 3, 32'hB3, 1'b1);
      idle(3);
    end

    // T3: sink 0 back-pressured with the register full
    mr[0] = 4'b1110;
    fork
      begin
        beat(0, 2'd0, 0, 32'hC0, 1'b0);
        beat(0, 2'd0, 0, 32'hC1, 1'b0);
        beat(0, 2'd0, 0, 32'hC2, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("t3_stall_sready", sr[0], 0);
        chk("t3_hold_valid", mv[0], 4'b0001);
        chk("t3_hold_data", md[0][31:0], 32'hC0);
        @(posedge clk);
        #1;
        mr[0] = 4'hF;
      end
    join
    idle(3);

    // T4: invalid target on the 3-sink instance
    errcnt = 0;
    c = cyc;
    beat(2, 2'd3, -1, 32'hD0, 1'b0);
    chk("t4_busy", bz[2], 1);
    beat(2, 2'd3, -1, 32'hD1, 1'b1);
    chk("t4_no_stall", cyc - c, 2);
    idle(3);
    chk("t4_selerr_pulses", errcnt, 1);
    beat(2, 2'd1, 1, 32'hD2, 1'b1);
    idle(3);

    // T5: reset mid-burst with the register full
    mr[0] = 4'h0;
    beat(0, 2'd1, -1, 32'hE0, 1'b0);
    chk("t5_busy_pre", bz[0], 1);
    chk("t5_full_pre", mv[0], 4'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_sready", sr[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_valid", mv[0], 0);
    chk("t5_post_busy", bz[0], 0);
    mr[0] = 4'hF;
    idle(1);
    beat(0, 2'd0, 0, 32'hF0, 1'b1);
    idle(3);

    // T6: back-to-back single-beat bursts, both modes
    for (int k = 0; k < 2; k++) begin
      c = cyc;
      for (int i = 0; i < 4; i++) begin
        beat(k, 2'(i), i, 32'h60 + i, 1'b1);
        chk($sformatf("t6_busy_d%0d", k), bz[k], 0);
      end
      chk($sformatf("t6_rate_d%0d", k), cyc - c, 4);
      idle(3);
    end

    idle(4);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
